// File: rtl/reg_wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package reg_wb_pkg;
  localparam int REG_WIDTH_DEF  = 32;
  localparam int FILE_DEPTH_DEF = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, set has priority over clear.
module wb_scoreboard
  import reg_wb_pkg::*;
#(
  parameter int FILE_DEPTH = FILE_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(FILE_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_set_valid,
  input  logic [ADDR_WIDTH-1:0] i_set_idx,
  input  logic                  i_clr_valid,
  input  logic [ADDR_WIDTH-1:0] i_clr_idx,
  output logic [FILE_DEPTH-1:0] o_pending
);

  logic [FILE_DEPTH-1:0] set_mask;
  logic [FILE_DEPTH-1:0] clr_mask;

  // x0 is hardwired, so it can never have an outstanding write.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_set_valid && (i_set_idx != '0)) set_mask[i_set_idx] = 1'b1;
    if (i_clr_valid) clr_mask[i_clr_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_pending <= '0;
    end else begin
      o_pending <= (o_pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-source register-file write arbiter: port 0 has priority, port 1 is protected by a starvation guard.
// Optional statistics counters are built when REG_WB_ARB_STATS_EN is defined.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int FILE_DEPTH = FILE_DEPTH_DEF,
  parameter int MAX_WAIT   = 4,
  localparam int ADDR_WIDTH = $clog2(FILE_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_p0_valid,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [REG_WIDTH-1:0]  i_p0_data,
  output logic                  o_p0_ready,
  input  logic                  i_p1_valid,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [REG_WIDTH-1:0]  i_p1_data,
  output logic                  o_p1_ready,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  output logic [FILE_DEPTH-1:0] o_pending,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [REG_WIDTH-1:0]  o_wr_data,
  output arb_state_e            o_arb_state
`ifdef REG_WB_ARB_STATS_EN
  ,
  output logic [31:0]           o_conflict_cnt,
  output logic [31:0]           o_starve_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  arb_state_e       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             p0_xfer, p1_xfer;

  // Handshake: a port transfers on valid & ready; the requester holds
  // valid/addr/data until ready; ready is combinational and never raised without valid.
  always_comb begin
    o_p0_ready    = i_p0_valid;
    o_p1_ready    = i_p1_valid & ~i_p0_valid;
    if (state == STARVE) begin
      o_p1_ready  = i_p1_valid;
      o_p0_ready  = i_p0_valid & ~i_p1_valid;
    end
    wait_cnt_next = wait_cnt;
    state_next    = state;
    // Served or withdrawn both end the wait; only continued denial advances it.
    if (!i_p1_valid || o_p1_ready) begin
      wait_cnt_next = '0;
      state_next    = NORMAL;
    end else begin
      if (wait_cnt != WAIT_LIMIT) wait_cnt_next = wait_cnt + 1'b1;
      if (wait_cnt_next == WAIT_LIMIT) state_next = STARVE;
    end
  end

  assign p0_xfer     = i_p0_valid & o_p0_ready;
  assign p1_xfer     = i_p1_valid & o_p1_ready;
  assign o_arb_state = state;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Writes to x0 are accepted but suppressed at the register file.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= 1'b0;
      if (p0_xfer) begin
        o_wr_en   <= (i_p0_addr != '0);
        o_wr_addr <= i_p0_addr;
        o_wr_data <= i_p0_data;
      end else if (p1_xfer) begin
        o_wr_en   <= (i_p1_addr != '0);
        o_wr_addr <= i_p1_addr;
        o_wr_data <= i_p1_data;
      end
    end
  end

  wb_scoreboard #(
    .FILE_DEPTH(FILE_DEPTH)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_set_valid(i_issue_valid),
    .i_set_idx  (i_issue_rd),
    .i_clr_valid(p1_xfer),
    .i_clr_idx  (i_p1_addr),
    .o_pending  (o_pending)
  );

`ifdef REG_WB_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_conflict_cnt <= '0;
      o_starve_cnt   <= '0;
    end else begin
      if (i_p0_valid && i_p1_valid && (o_conflict_cnt != '1))
        o_conflict_cnt <= o_conflict_cnt + 32'd1;
      if ((state == NORMAL) && (state_next == STARVE))
        o_starve_cnt <= o_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a write-port scoreboard queue and a pending-bitmap model.
module tb_reg_wb_arbiter;
  import reg_wb_pkg::*;

  localparam int W = 38;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_p0_valid;
  logic [4:0]  i_p0_addr;
  logic [31:0] i_p0_data;
  logic        o_p0_ready;
  logic        i_p1_valid;
  logic [4:0]  i_p1_addr;
  logic [31:0] i_p1_data;
  logic        o_p1_ready;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [31:0] o_pending;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  arb_state_e  o_arb_state;
`ifdef REG_WB_ARB_STATS_EN
  logic [31:0] o_conflict_cnt;
  logic [31:0] o_starve_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [4:0]   mdl_addr;
  logic [31:0]  mdl_data;
  logic [31:0]  mdl_pend;

  reg_wb_arbiter #(.REG_WIDTH(32), .FILE_DEPTH(32), .MAX_WAIT(4)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_p0_valid   (i_p0_valid),
    .i_p0_addr    (i_p0_addr),
    .i_p0_data    (i_p0_data),
    .o_p0_ready   (o_p0_ready),
    .i_p1_valid   (i_p1_valid),
    .i_p1_addr    (i_p1_addr),
    .i_p1_data    (i_p1_data),
    .o_p1_ready   (o_p1_ready),
    .i_issue_valid(i_issue_valid),
    .i_issue_rd   (i_issue_rd),
    .o_pending    (o_pending),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_arb_state  (o_arb_state)
`ifdef REG_WB_ARB_STATS_EN
    ,
    .o_conflict_cnt(o_conflict_cnt),
    .o_starve_cnt  (o_starve_cnt)
`endif
  );

  // Clock and watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check readies, predict, then check registered outputs after posedge.
  task automatic drive(input logic p0v, input logic [4:0] p0a, input logic [31:0] p0d,
                       input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d,
                       input logic iv, input logic [4:0] ird,
                       input logic er0, input logic er1);
    logic         exp_en;
    logic [W-1:0] exp_rec;
    i_p0_valid = p0v; i_p0_addr = p0a; i_p0_data = p0d;
    i_p1_valid = p1v; i_p1_addr = p1a; i_p1_data = p1d;
    i_issue_valid = iv; i_issue_rd = ird;
    #1;
    chk("p0_ready", 64'(o_p0_ready), 64'(er0));
    chk("p1_ready", 64'(o_p1_ready), 64'(er1));
    exp_en = 1'b0;
    if (er0) begin
      exp_en = (p0a != 5'd0); mdl_addr = p0a; mdl_data = p0d;
    end else if (er1) begin
      exp_en = (p1a != 5'd0); mdl_addr = p1a; mdl_data = p1d;
      mdl_pend[p1a] = 1'b0;
    end
    if (iv && (ird != 5'd0)) mdl_pend[ird] = 1'b1;
    exp_q.push_back({exp_en, mdl_addr, mdl_data});
    @(posedge i_clk);
    #1;
    exp_rec = exp_q.pop_front();
    chk("wr_port", 64'({o_wr_en, o_wr_addr, o_wr_data}), 64'(exp_rec));
    chk("pending", 64'(o_pending), 64'(mdl_pend));
    @(negedge i_clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic contend(input logic [31:0] p0d, input logic er0, input logic er1);
    drive(1'b1, 5'd3, p0d, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, er0, er1);
  endtask

  task automatic model_reset();
    mdl_addr = '0; mdl_data = '0; mdl_pend = '0;
    exp_q.delete();
  endtask

  task automatic do_reset(input logic keep_traffic);
    i_reset_n = 1'b0;
    i_p0_valid = keep_traffic; i_p1_valid = keep_traffic; i_issue_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rst_wr_en", 64'(o_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(o_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(o_wr_data), 64'd0);
    chk("rst_pending", 64'(o_pending), 64'd0);
    chk("rst_state", 64'(o_arb_state), 64'(NORMAL));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_p0_valid = 0; i_p0_addr = 0; i_p0_data = 0;
    i_p1_valid = 0; i_p1_addr = 0; i_p1_data = 0;
    i_issue_valid = 0; i_issue_rd = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    do_reset(1'b0);

    // Port 0 alone, then idle holds addr/data with write enable low
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
    idle();
    // x0 write accepted but not enabled
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);

    // Scoreboard set, x0 issue ignored, clear by port-1 transfer, set wins
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 0, 0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, 0, 0);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h55, 0, 5'd0, 0, 1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 0, 0);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h66, 1, 5'd9, 0, 1);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h77, 0, 5'd0, 0, 1);

    // Contention: four p0 grants, then p1, then p0 again
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 0, 0);
    for (int k = 0; k < 4; k++) contend(32'(100 + k), 1'b1, 1'b0);
    contend(32'd200, 1'b0, 1'b1);
    contend(32'd201, 1'b1, 1'b0);
    idle();

    // Withdrawn port-1 request restarts the wait count
    for (int k = 0; k < 3; k++) contend(32'(300 + k), 1'b1, 1'b0);
    drive(1, 5'd3, 32'd310, 0, 5'd7, 32'h1234, 0, 5'd0, 1, 0);
    for (int k = 0; k < 4; k++) contend(32'(320 + k), 1'b1, 1'b0);
    contend(32'd330, 1'b0, 1'b1);
    idle();

    // Random single-source traffic
    for (int k = 0; k < 6; k++) begin
      logic [4:0]  a;
      logic [31:0] d;
      logic        use_p1;
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      use_p1 = 1'($urandom_range(0, 1));
      if (use_p1) drive(0, 5'd0, 32'd0, 1, a, d, 0, 5'd0, 0, 1);
      else        drive(1, a, d, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
    end

    // Reset mid-operation drops the in-flight grant and clears the scoreboard
    drive(1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 1, 5'd12, 1, 0);
    for (int k = 0; k < 3; k++) contend(32'(400 + k), 1'b1, 1'b0);
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) contend(32'(500 + k), 1'b1, 1'b0);
    contend(32'd510, 1'b0, 1'b1);
    idle();

`ifdef REG_WB_ARB_STATS_EN
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) contend(32'(600 + k), 1'b0, 1'b1);
      else                  contend(32'(600 + k), 1'b1, 1'b0);
    end
    chk("conflict_cnt", 64'(o_conflict_cnt), 64'd10);
    chk("starve_cnt", 64'(o_starve_cnt), 64'd2);
    idle();
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - port 0: in-order pipeline Write Back stage;
  - port 1: long-latency unit (mul/div, load miss).
- Fixed priority to port 0, with a starvation guard so port 1 is eventually served.
- Tracks destinations with an outstanding port-1 write in a scoreboard that decode uses for hazard stalls.
- Sits between WB and the register file write port; all outputs registered on posedge.

Parameters:
- REG_WIDTH, 32: data width of the register file.
- FILE_DEPTH, 32: number of architectural registers.
- MAX_WAIT, 4: cycles port 1 may be denied before it takes priority; legal range ≥1.
- ADDR_WIDTH, $clog2(FILE_DEPTH): derived, not adjustable.

Ports:
- i_clk  in  1  clock, posedge.
- i_reset_n  in  1  synchronous active-low reset.
- i_p0_valid  in  1  pipeline WB write request.
- i_p0_addr  in  ADDR_WIDTH  pipeline destination.
- i_p0_data  in  REG_WIDTH  pipeline write data.
- o_p0_ready  out  1  port 0 accepted this cycle.
- i_p1_valid  in  1  long-latency unit write request.
- i_p1_addr  in  ADDR_WIDTH  long-latency destination.
- i_p1_data  in  REG_WIDTH  long-latency write data.
- o_p1_ready  out  1  port 1 accepted this cycle.
- i_issue_valid  in  1  long-latency op issued.
- i_issue_rd  in  ADDR_WIDTH  its destination.
- o_pending  out  FILE_DEPTH  scoreboard bitmap; bit n = write to xn outstanding.
- o_wr_en  out  1  register file write enable.
- o_wr_addr  out  ADDR_WIDTH  register file write address.
- o_wr_data  out  REG_WIDTH  register file write data.

Behaviour:
- Reset is synchronous and active-low on i_clk.
  - Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_pending=0, wait_cnt=0, FSM=NORMAL.
  - Reset mid-operation discards any in-flight grant and clears the scoreboard.
- Handshake:
  - Transfer on valid&ready.
  - Requester holds valid/addr/data stable until ready.
  - Ready is combinational from valids and state; a ready is never asserted without its valid.
- FSM, state NORMAL:
  - o_p0_ready=i_p0_valid.
  - o_p1_ready=i_p1_valid&!i_p0_valid.
- FSM, state STARVE:
  - o_p1_ready=i_p1_valid.
  - o_p0_ready=i_p0_valid&!i_p1_valid.
- Starvation counter:
  - wait_cnt increments (saturating at MAX_WAIT) each cycle i_p1_valid&!o_p1_ready.
  - It clears on a port-1 transfer.
  - NORMAL→STARVE when wait_cnt reaches MAX_WAIT.
  - STARVE→NORMAL on the port-1 transfer.
  - If i_p1_valid drops without a transfer (illegal), return to NORMAL and clear wait_cnt.
- Latency:
  - A transfer accepted in cycle N drives o_wr_en/addr/data during cycle N+1.
  - The register file commits it on the negedge of N+1.
  - With no transfer, o_wr_en=0 next cycle and addr/data hold their last values.
- x0 handling:
  - A request to x0 is accepted normally but produces o_wr_en=0.
  - i_issue_rd=0 never sets a scoreboard bit.
- Scoreboard:
  - i_issue_valid sets bit i_issue_rd next cycle.
  - A port-1 transfer clears bit i_p1_addr next cycle.
  - Simultaneous set and clear of the same bit: set wins.
  - Port-0 transfers never touch the scoreboard.
- Both ports request the same address in the same cycle: arbitration rules alone apply; the loser's write lands a cycle later and overwrites.

Optional Feature:
- Macro: REG_WB_ARB_STATS_EN.
- With the macro defined:
  - Adds output o_conflict_cnt (32 bits), reset 0.
  - Increments, saturating at all-ones, every cycle both valids are high.
  - Adds output o_starve_cnt (32 bits), reset 0; increments on each NORMAL→STARVE transition.
- Without the macro: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package reg_wb_pkg:
  - typedef arb_state_e {NORMAL, STARVE};
  - default constants REG_WIDTH_DEF=32, FILE_DEPTH_DEF=32.
- One natural sub-module, wb_scoreboard: the pending bitmap with set/clear ports and set-wins priority.
- Arbiter FSM, counter and output register stay in the top.

Test Plan:
- Reset mid-operation: drive traffic, pulse i_reset_n low for one cycle → next cycle o_wr_en=0, o_pending=0, and port 0 alone gets granted immediately.
- Port 0 alone: p0 addr 5, data 0xDEADBEEF at cycle N → o_p0_ready=1 at N; o_wr_en=1, addr 5, data 0xDEADBEEF at N+1.
- Contention, MAX_WAIT=4: both valid continuously (p1 addr 7, data 0x1234) → p0 granted 4 cycles; p1 granted on cycle 5 with o_p0_ready=0; p0 granted again on cycle 6.
- x0 write: p0 addr 0, data 0xFFFFFFFF → o_p0_ready=1, next cycle o_wr_en=0.
- Scoreboard: issue rd=9 → o_pending[9]=1 next cycle; p1 transfer addr 9 → bit clears; same-cycle issue rd=9 with p1 transfer addr 9 → bit stays 1.
- Stats (REG_WB_ARB_STATS_EN): 10 cycles of dual-valid contention, MAX_WAIT=4 → o_conflict_cnt=10, o_starve_cnt=2.
